spi_master: RTL and testbench
=============================

# spi_master

SPI master that issues single-byte read and write transactions to the on-board SPI memory slave over `sclk`/`cs`/`mosi`/`miso`, sitting directly upstream of it. A host-side request (7-bit address, rw flag, 8-bit write data) becomes one 16-bit mode-0 frame, MSB first, with SCLK half-periods long enough to pass through the slave's input conditioners. For reads, the byte the slave returns is captured into `rdata`. Completion is signalled with a one-cycle `done` pulse.

## Interface
- `HALF_PERIOD`, 16: clk cycles per SCLK half-period; legal range 2..255 (4..255 with sync enabled).
- `clk` input 1: system clock; all logic on posedge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: request strobe; accepted only in IDLE.
- `rw` input 1: 1 = read, 0 = write; captured at accept.
- `addr` input 7: memory address; captured at accept.
- `wdata` input 8: write byte; captured at accept; ignored for reads.
- `busy` output 1: high from the cycle after accept until return to IDLE.
- `done` output 1: one-cycle pulse on return to IDLE.
- `rdata` output 8: last read byte; holds until the next read completes.
- `sclk` output 1: SPI clock; idles low.
- `cs` output 1: chip select, active-low; idles high.
- `mosi` output 1: serial data to slave.
- `miso` input 1: serial data from slave.

## Operation
- Frame is {addr[6:0], rw, data[7:0]}, sent MSB first. Data is `wdata` for writes and 8'h00 for reads.
- States:
  - IDLE: `cs`=1, `sclk`=0, `busy`=0. On `start`, capture `rw`, `addr`, `wdata`, load the 16-bit shift register, go to SETUP.
  - SETUP: `cs`=0, `sclk`=0, `mosi`=frame bit 15; lasts H cycles, then HIGH.
  - HIGH: `sclk`=1; lasts H cycles, then LOW.
  - LOW: `sclk`=0, `mosi` shifts to the next bit on entry; lasts H cycles. Go to HIGH if bits remain; after the 16th bit go to GAP.
  - GAP: `cs`=1, `mosi`=0; lasts H cycles, then IDLE with `done`=1.
- `miso` is sampled on the clk edge where `sclk` goes 0→1, for rising edges 9..16 only. Samples shift into the read register MSB first.
- `rdata` updates on entry to IDLE, and only for reads.
- Bit counter is 4 bits and counts 0..15. The half-period counter is 8 bits, reloads to H−1 on every state entry, and advances the state at 0.
- `start` outside IDLE is ignored: no queueing, no error.
- `start` in the same cycle `done` is high is accepted.
- `rw`, `addr`, and `wdata` may change freely after accept.

## Timing
- Reset values, applied next edge with `reset_n`=0: state IDLE, `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=8'h00, counters 0.
- Reset mid-frame aborts immediately: `cs` rises next cycle, no `done` pulse, `rdata` is cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge 0. From edge 1: `cs`=0, `busy`=1, `mosi`=bit 15.
- First `sclk` rise at edge 1+H. Rising edge k of the frame falls at edge 1+H+2H·(k−1).
- `cs` rises at edge 1+33H. `done` is high and `busy` low at edge 1+34H.
- Accept-to-done latency is 34H+1 cycles (545 at H=16).

## Configuration
- `SPI_MASTER_MISO_SYNC_EN` defined: `miso` passes through a 2-flop synchronizer before sampling. Sampling still occurs on the `sclk` rise edge, using the synchronized value, so slave data must settle by 2 cycles before the rise. `HALF_PERIOD` ≥ 4 is required.
- Not defined: `miso` is sampled directly.
- Frame timing, `done`, and `busy` are identical in both builds.

## Structure
- Shared package `spi_pkg`:
  - state enum {IDLE, SETUP, HIGH, LOW, GAP};
  - `SPI_RW_READ`=1'b1, `SPI_RW_WRITE`=1'b0;
  - `SPI_FRAME_BITS`=16, `SPI_ADDR_BITS`=7, `SPI_DATA_BITS`=8.
- One sub-module, `spi_halfperiod_timer`: loadable 8-bit down-counter producing an `expire` pulse. The FSM, shift register, and read register live in `spi_master`.

## Test plan
- Write, H=16, addr 7'h05, `wdata` 8'hA5, `rw`=0:
  - `mosi` at the 16 rising edges = 0000101_0_10100101;
  - `done` at cycle 545; `rdata` stays 8'h00.
- Read, addr 7'h12, behavioural slave drives 8'h3C after rising edge 8 (changing on `sclk` falls):
  - address bits = 0010010_1, data bits all 0;
  - `rdata`=8'h3C when `done` pulses.
- `start` pulsed at cycle 100 of an active frame → ignored; exactly one `done`; frame unchanged.
- `reset_n` low at rising edge 6 → next cycle `cs`=1, `sclk`=0, `busy`=0, `rdata`=0; no `done`.
- Back-to-back: `start` held high across `done` → second frame's `cs` falls 1 cycle after `done`; `cs` high-time between frames ≥ H.
- H=2 with a read of 8'hFF, both builds → `rdata`=8'hFF, latency 69 cycles. In the sync build, H=4 with latency 137.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master states, frame geometry and rw encoding.
package spi_pkg;
  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_ADDR_BITS = 7;
  localparam int SPI_DATA_BITS = 8;
  localparam logic SPI_RW_READ = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_e;
endpackage

// File: rtl/spi_halfperiod_timer.sv
// spi_halfperiod_timer: loadable 8-bit down-counter, expire while the count sits at zero.
module spi_halfperiod_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       expire_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= 8'd0;
    else if (load_i) cnt_q <= load_val_i;
    else if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
  end
  assign expire_o = cnt_q == 8'd0;
endmodule

// File: rtl/spi_master.sv
// spi_master: single-byte mode-0 SPI read/write master, 16-bit MSB-first frames.
// Define SPI_MASTER_MISO_SYNC_EN to pass miso through a 2-flop synchronizer (HALF_PERIOD >= 4).
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     rw,
  input  logic [SPI_ADDR_BITS-1:0] addr,
  input  logic [SPI_DATA_BITS-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic [SPI_DATA_BITS-1:0] rdata,
  output logic                     sclk,
  output logic                     cs,
  output logic                     mosi,
  input  logic                     miso
);
  state_e state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] sreg_q, sreg_d;
  logic [SPI_DATA_BITS-1:0] rx_q, rx_d, rdata_q;
  logic [3:0] bit_q, bit_d;
  logic rw_q, rw_d, done_pre_q, done_q, busy_q, sclk_q, cs_q, mosi_q;
  logic expire, miso_smp;
`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= !reset_n ? 2'b00 : {sync_q[0], miso};
  assign miso_smp = sync_q[1];
`else
  assign miso_smp = miso;
`endif
  spi_halfperiod_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (state_d != state_q),
    .load_val_i(8'(HALF_PERIOD - 1)),
    .expire_o  (expire)
  );
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    bit_d = bit_q;
    rw_d = rw_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        rw_d = rw;
        bit_d = 4'd0;
        sreg_d = {addr, rw, rw == SPI_RW_READ ? 8'h00 : wdata};
      end
      SETUP: state_d = expire ? HIGH : SETUP;
      HIGH: if (expire) begin
        state_d = LOW;
        sreg_d = {sreg_q[SPI_FRAME_BITS-2:0], 1'b0};
      end
      LOW: if (expire) begin
        state_d = bit_q == 4'(SPI_FRAME_BITS - 1) ? GAP : HIGH;
        bit_d = bit_q + 4'd1;
      end
      GAP: state_d = expire ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // sclk_q still low in the first HIGH cycle marks the registered rising edge
  assign rx_d = (state_q == HIGH && !sclk_q && bit_q >= 4'(SPI_FRAME_BITS - SPI_DATA_BITS))
              ? {rx_q[SPI_DATA_BITS-2:0], miso_smp} : rx_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q <= '0;
      rx_q <= '0;
      rdata_q <= '0;
      bit_q <= 4'd0;
      rw_q <= SPI_RW_WRITE;
      done_pre_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      cs_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      rw_q <= rw_d;
      done_pre_q <= state_q == GAP && expire;
      done_q <= done_pre_q;
      rdata_q <= done_pre_q && rw_q == SPI_RW_READ ? rx_q : rdata_q;
      busy_q <= state_q != IDLE;
      sclk_q <= state_q == HIGH;
      cs_q <= state_q == IDLE || state_q == GAP;
      mosi_q <= (state_q == SETUP || state_q == HIGH || state_q == LOW) ? sreg_q[SPI_FRAME_BITS-1] : 1'b0;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign rdata = rdata_q;
  assign sclk = sclk_q;
  assign cs = cs_q;
  assign mosi = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table vectors, corner sequences and random frames against a frame-level model.
module tb_spi_master;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int H_SMALL = 4;
  localparam int LAT_S = 137;
`else
  localparam int H_SMALL = 2;
  localparam int LAT_S = 69;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_s [2];
  logic rw_s [2];
  logic [6:0] addr_s [2];
  logic [7:0] wdata_s [2];
  logic busy_s [2];
  logic done_s [2];
  logic [7:0] rdata_s [2];
  logic sclk_s [2];
  logic cs_s [2];
  logic mosi_s [2];
  logic [7:0] sbyte [2];
  logic [7:0] mdl_rd [2];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    logic miso = 1'b0;
    logic sclk_p = 1'b0;
    int rises = 0;
    spi_master #(.HALF_PERIOD(g == 0 ? 16 : H_SMALL)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start_s[g]), .rw(rw_s[g]), .addr(addr_s[g]),
      .wdata(wdata_s[g]), .busy(busy_s[g]), .done(done_s[g]), .rdata(rdata_s[g]),
      .sclk(sclk_s[g]), .cs(cs_s[g]), .mosi(mosi_s[g]), .miso(miso)
    );
    // slave: junk outside the data phase, read byte MSB first changing on sclk falls after rise 8
    always @(negedge clk) begin
      sclk_p <= sclk_s[g];
      if (cs_s[g]) begin
        rises <= 0;
        miso <= 1'($urandom);
      end else if (sclk_s[g] && !sclk_p) rises <= rises + 1;
      else if (!sclk_s[g] && sclk_p) miso <= (rises >= 8 && rises < 16) ? sbyte[g][15-rises] : 1'($urandom);
    end
  end
  function automatic int hp(input int d);
    return d == 0 ? 16 : H_SMALL;
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic run_frame(input int d, input logic r, input logic [6:0] a, input logic [7:0] w,
                           input logic [7:0] sb, input int poke_n, input int rst_rise, input bit hold,
                           output logic [15:0] fr, output int lat, output logic [7:0] rd,
                           output int cs_hi_n, output int rise1_n);
    int h = hp(d);
    int nr = 0;
    bit sp = 1'b0;
    fr = '0; lat = -1; rd = '0; cs_hi_n = -1; rise1_n = -1;
    sbyte[d] = sb; rw_s[d] = r; addr_s[d] = a; wdata_s[d] = w; start_s[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start_s[d] = 1'b0;
    rw_s[d] = 1'($urandom); addr_s[d] = 7'($urandom); wdata_s[d] = 8'($urandom);
    for (int n = 1; n <= 40 * h; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_after_accept", busy_s[d], 1);
      if (n == poke_n) begin start_s[d] = 1'b1; addr_s[d] = 7'h7F; rw_s[d] = 1'b1; end
      if (n == poke_n + 1) start_s[d] = 1'b0;
      if (sclk_s[d] && !sp) begin
        nr++;
        fr = {fr[14:0], mosi_s[d]};
        if (nr == 1) rise1_n = n;
      end
      sp = sclk_s[d];
      if (cs_s[d] && cs_hi_n < 0) cs_hi_n = n;
      if (rst_rise > 0 && nr == rst_rise) begin
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_cs", cs_s[d], 1);
        chk("rst_sclk", sclk_s[d], 0);
        chk("rst_busy", busy_s[d], 0);
        chk("rst_done", done_s[d], 0);
        chk("rst_rdata", rdata_s[d], 0);
        reset_n = 1'b1;
        return;
      end
      if (done_s[d]) begin
        lat = n;
        rd = rdata_s[d];
        chk("busy_at_done", busy_s[d], 0);
        break;
      end
    end
    chk("done_seen", lat > 0, 1);
  endtask
  typedef struct {
    int d;
    logic rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] sb;
    logic [15:0] frame;
    int lat;
    logic [7:0] rdata;
  } vec_t;
  initial begin
    vec_t tbl [4];
    logic [15:0] fr;
    logic [7:0] rd;
    int lat, cs_hi, r1, h, cnt;
    tbl[0] = '{0, 1'b0, 7'h05, 8'hA5, 8'h5A, 16'h0AA5, 545, 8'h00};
    tbl[1] = '{0, 1'b1, 7'h12, 8'hC3, 8'h3C, 16'h2500, 545, 8'h3C};
    tbl[2] = '{1, 1'b1, 7'h7F, 8'h00, 8'hFF, 16'hFF00, LAT_S, 8'hFF};
    tbl[3] = '{1, 1'b0, 7'h00, 8'hFF, 8'h00, 16'h00FF, LAT_S, 8'hFF};
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; rw_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0; sbyte[d] = '0; mdl_rd[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_cs", cs_s[d], 1);
      chk("reset_sclk", sclk_s[d], 0);
      chk("reset_mosi", mosi_s[d], 0);
      chk("reset_busy", busy_s[d], 0);
      chk("reset_done", done_s[d], 0);
      chk("reset_rdata", rdata_s[d], 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      h = hp(tbl[i].d);
      run_frame(tbl[i].d, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].sb, -10, 0, 1'b0, fr, lat, rd, cs_hi, r1);
      chk("tbl_frame", fr, tbl[i].frame);
      chk("tbl_latency", lat, tbl[i].lat);
      chk("tbl_rdata", rd, tbl[i].rdata);
      chk("tbl_first_rise", r1, 1 + h);
      chk("tbl_cs_rise", cs_hi, 1 + 33 * h);
      mdl_rd[tbl[i].d] = tbl[i].rdata;
    end
    run_frame(0, 1'b0, 7'h33, 8'h9C, 8'h00, 100, 0, 1'b0, fr, lat, rd, cs_hi, r1);
    chk("poke_frame", fr, {7'h33, 1'b0, 8'h9C});
    chk("poke_latency", lat, 545);
    cnt = 0;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      cnt += int'(done_s[0]) + int'(!cs_s[0]);
    end
    chk("poke_no_second_frame", cnt, 0);
    run_frame(0, 1'b1, 7'h21, 8'h00, 8'h77, -10, 6, 1'b0, fr, lat, rd, cs_hi, r1);
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    cnt = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      cnt += int'(done_s[0]) + int'(!cs_s[0]);
    end
    chk("rst_quiet_after", cnt, 0);
    h = hp(1);
    run_frame(1, 1'b0, 7'h4B, 8'h1E, 8'h00, -10, 0, 1'b1, fr, lat, rd, cs_hi, r1);
    chk("b2b_frame", fr, {7'h4B, 1'b0, 8'h1E});
    @(negedge clk);
    start_s[1] = 1'b0;
    chk("b2b_cs_fall", cs_s[1], 0);
    chk("b2b_cs_gap", (lat + 1) - cs_hi, h + 1);
    lat = -1;
    for (int m = 2; m <= 40 * h; m++) begin
      @(negedge clk);
      if (done_s[1]) begin lat = m; break; end
    end
    chk("b2b_second_latency", lat, 34 * h + 1);
    mdl_rd[1] = rdata_s[1] == 8'h00 ? mdl_rd[1] : rdata_s[1];
    for (int i = 0; i < 24; i++) begin
      logic r;
      logic [6:0] a;
      logic [7:0] w, sb, exp_rd;
      r = 1'($urandom); a = 7'($urandom); w = 8'($urandom); sb = 8'($urandom);
      exp_rd = r ? sb : mdl_rd[1];
      run_frame(1, r, a, w, sb, -10, 0, 1'b0, fr, lat, rd, cs_hi, r1);
      chk("rnd_frame", fr, {a, r, r ? 8'h00 : w});
      chk("rnd_latency", lat, 34 * h + 1);
      chk("rnd_rdata", rd, exp_rd);
      mdl_rd[1] = exp_rd;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
